// File: rtl/km_mul_pipe.sv
// Three-stage one-level Karatsuba multiplier with valid/ready flow control,
// a sideband tag carried alongside each operation, and a squaring mode.
module km_mul_pipe #(
    parameter int DW   = 32,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode,
    input  logic [DW-1:0]   in1,
    input  logic [DW-1:0]   in2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TAGW-1:0] out_tag,
    output logic [DW-1:0]   out_L,
    output logic [DW-1:0]   out_H
);

    localparam int H  = DW / 2;
    localparam int MW = DW + 2;
    localparam int PW = 2 * DW;

    logic            w_adv;
    logic [3:1]      r_v;

    // Stage 1: operand halves and half sums
    logic [DW-1:0]   w_b;
    logic [H:0]      w_sa;
    logic [H:0]      w_sb;
    logic [H-1:0]    r1_ah, r1_al, r1_bh, r1_bl;
    logic [H:0]      r1_sa, r1_sb;
    logic [TAGW-1:0] r1_tag;

    // Stage 2: the three partial products
    logic [DW-1:0]   r2_z2, r2_z0;
    logic [MW-1:0]   r2_z1;
    logic [TAGW-1:0] r2_tag;

    // Stage 3: recombined product (output register)
    logic [MW-1:0]   w_mid;
    logic [PW-1:0]   w_p;
    logic [DW-1:0]   r3_l, r3_h;
    logic [TAGW-1:0] r3_tag;

    // Stalls are global: the whole pipe freezes while a result waits downstream.
    assign w_adv    = !r_v[3] || out_ready;
    assign in_ready = w_adv;

    assign w_b  = mode ? in1 : in2;
    assign w_sa = {1'b0, in1[DW-1:H]} + {1'b0, in1[H-1:0]};
    assign w_sb = {1'b0, w_b[DW-1:H]} + {1'b0, w_b[H-1:0]};

    // z1 >= z2 + z0 always, so the middle term cannot wrap below zero.
    assign w_mid = r2_z1 - MW'(r2_z2) - MW'(r2_z0);
    assign w_p   = (PW'(r2_z2) << DW) + (PW'(w_mid) << H) + PW'(r2_z0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (w_adv) begin
            r_v <= {r_v[2:1], in_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_ah  <= '0;
            r1_al  <= '0;
            r1_bh  <= '0;
            r1_bl  <= '0;
            r1_sa  <= '0;
            r1_sb  <= '0;
            r1_tag <= '0;
        end else if (w_adv && in_valid) begin
            r1_ah  <= in1[DW-1:H];
            r1_al  <= in1[H-1:0];
            r1_bh  <= w_b[DW-1:H];
            r1_bl  <= w_b[H-1:0];
            r1_sa  <= w_sa;
            r1_sb  <= w_sb;
            r1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_z2  <= '0;
            r2_z0  <= '0;
            r2_z1  <= '0;
            r2_tag <= '0;
        end else if (w_adv && r_v[1]) begin
            r2_z2  <= DW'(r1_ah) * DW'(r1_bh);
            r2_z0  <= DW'(r1_al) * DW'(r1_bl);
            r2_z1  <= MW'(r1_sa) * MW'(r1_sb);
            r2_tag <= r1_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_l   <= '0;
            r3_h   <= '0;
            r3_tag <= '0;
        end else if (w_adv && r_v[2]) begin
            r3_l   <= w_p[DW-1:0];
            r3_h   <= w_p[PW-1:DW];
            r3_tag <= r2_tag;
        end
    end

    assign out_valid = r_v[3];
    assign out_L     = r3_l;
    assign out_H     = r3_h;
    assign out_tag   = r3_tag;

endmodule

// File: tb/tb_km_mul_pipe.sv
// Directed and randomized checks of km_mul_pipe: latency, carry corners,
// squaring, backpressure, asynchronous reset with ops in flight, ordering.
module tb_km_mul_pipe;

    localparam int DW   = 32;
    localparam int TAGW = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            mode;
    logic [DW-1:0]   in1;
    logic [DW-1:0]   in2;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [TAGW-1:0] out_tag;
    logic [DW-1:0]   out_L;
    logic [DW-1:0]   out_H;

    int n_vec = 0;
    int n_err = 0;

    km_mul_pipe #(.DW(DW), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in1       (in1),
        .in2       (in2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_L     (out_L),
        .out_H     (out_H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one op into an empty pipe; lat = edges counted from (and including) the accepting edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                         input logic [3:0] tg, output int lat,
                         output logic [31:0] h, output logic [31:0] l, output logic [3:0] t);
        in1 = a; in2 = b; mode = m; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            in_valid = 1'b0;
            in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; in_tag = 4'hF;
        end while (!out_valid && lat < 10);
        h = out_H; l = out_L; t = out_tag;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
        in1 = '0; in2 = '0; in_tag = '0;
        tick(); tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_L !== 32'h0) begin n_err++; $display("FAIL reset_out_L: got %h want 0", out_L); end
        n_vec++; if (out_H !== 32'h0) begin n_err++; $display("FAIL reset_out_H: got %h want 0", out_H); end
        n_vec++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_basic;
        int lat; logic [31:0] h, l; logic [3:0] t;
        do_op(32'd3, 32'd5, 1'b0, 4'd1, lat, h, l, t);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d edges want 3", lat); end
        n_vec++; if (h !== 32'h0) begin n_err++; $display("FAIL basic_H: got %h want 0", h); end
        n_vec++; if (l !== 32'd15) begin n_err++; $display("FAIL basic_L: got %0d want 15", l); end
        n_vec++; if (t !== 4'd1) begin n_err++; $display("FAIL basic_tag: got %0d want 1", t); end
    endtask

    task automatic test_carry;
        int lat; logic [31:0] h, l; logic [3:0] t;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd2, lat, h, l, t);
        n_vec++; if ({h, l} !== 64'hFFFF_FFFE_0000_0001 || t !== 4'd2) begin
            n_err++; $display("FAIL carry_ones: got %h_%h tag %0d want fffffffe_00000001 tag 2", h, l, t); end
        do_op(32'h0001_0000, 32'h0001_0000, 1'b0, 4'd3, lat, h, l, t);
        n_vec++; if ({h, l} !== 64'h0000_0001_0000_0000 || t !== 4'd3) begin
            n_err++; $display("FAIL carry_mid: got %h_%h tag %0d want 00000001_00000000 tag 3", h, l, t); end
        do_op(32'h8000_0000, 32'h0000_0002, 1'b0, 4'd4, lat, h, l, t);
        n_vec++; if ({h, l} !== 64'h0000_0001_0000_0000) begin
            n_err++; $display("FAIL carry_msb: got %h_%h want 00000001_00000000", h, l); end
    endtask

    task automatic test_square;
        int lat; logic [31:0] h, l; logic [3:0] t; logic [63:0] e;
        e = 64'(32'd343576576) * 64'(32'd343576576);
        do_op(32'd343576576, 32'd123, 1'b1, 4'd5, lat, h, l, t);
        n_vec++; if ({h, l} !== e || t !== 4'd5) begin
            n_err++; $display("FAIL square: got %h_%h tag %0d want %h tag 5", h, l, t, e); end
        do_op(32'hFFFF_FFFF, 32'd0, 1'b1, 4'd6, lat, h, l, t);
        n_vec++; if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin
            n_err++; $display("FAIL square_ones: got %h_%h want fffffffe_00000001", h, l); end
    endtask

    task automatic test_backpressure;
        int issued = 0; int rcvd = 0; int cyc = 0; int stalls = 0;
        logic snap_ok = 1'b0;
        logic [31:0] sh, sl; logic [3:0] st; logic [63:0] e;
        while ((issued < 8 || rcvd < 8) && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            in_valid  = (issued < 8);
            in1 = 32'(issued * 1000 + 7); in2 = 32'(issued + 3); mode = 1'b0; in_tag = issued[3:0];
            #1;
            if (snap_ok) begin
                n_vec++;
                if ({out_valid, out_tag, out_H, out_L} !== {1'b1, st, sh, sl}) begin
                    n_err++; $display("FAIL bp_hold: got v%b tag %0d %h_%h want v1 tag %0d %h_%h",
                                      out_valid, out_tag, out_H, out_L, st, sh, sl); end
                snap_ok = 1'b0;
            end
            if (out_valid && !out_ready) begin
                stalls++;
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0 in stall", in_ready); end
                sh = out_H; sl = out_L; st = out_tag; snap_ok = 1'b1;
            end
            if (out_valid && out_ready) begin
                e = 64'(rcvd * 1000 + 7) * 64'(rcvd + 3);
                n_vec++;
                if (out_tag !== rcvd[3:0] || {out_H, out_L} !== e) begin
                    n_err++; $display("FAIL bp_result: got tag %0d %h_%h want tag %0d %h", out_tag, out_H, out_L, rcvd, e); end
                rcvd++;
            end
            if (in_valid && in_ready) issued++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (issued != 8 || rcvd != 8) begin
            n_err++; $display("FAIL bp_count: got issued %0d received %0d want 8 8", issued, rcvd); end
        n_vec++; if (stalls != 4) begin n_err++; $display("FAIL bp_stalls: got %0d held cycles want 4", stalls); end
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] h, l; logic [3:0] t; logic seen = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in1 = 32'(1000 + i); in2 = 32'(1000 + i); in_tag = 4'(9 + i);
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_L !== 32'd1000000) begin
            n_err++; $display("FAIL rstmid_pre: got v%b L %0d want v1 L 1000000", out_valid, out_L); end
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_L !== 32'h0 || out_H !== 32'h0) begin
            n_err++; $display("FAIL rstmid_async: got v%b %h_%h want v0 0_0", out_valid, out_H, out_L); end
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_ghost: got a result after reset want none"); end
        do_op(32'd7, 32'd9, 1'b0, 4'd13, lat, h, l, t);
        n_vec++; if (lat != 3 || l !== 32'd63 || h !== 32'd0 || t !== 4'd13) begin
            n_err++; $display("FAIL rstmid_first: got lat %0d %h_%h tag %0d want lat 3 0_3f tag 13", lat, h, l, t); end
    endtask

    task automatic test_random;
        logic [67:0] sbq[$];
        logic [67:0] got_e;
        logic [31:0] pa, pb; logic pm; logic offer = 1'b0;
        logic [63:0] e;
        int issued = 0; int cyc = 0;
        pa = $urandom_range(0, 343576576); pb = $urandom_range(0, 343576576); pm = 1'($urandom);
        while ((issued < 1000 || sbq.size() > 0) && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!offer) offer = (issued < 1000) && ($urandom_range(0, 4) != 0);
            if (offer) begin
                in_valid = 1'b1; in1 = pa; in2 = pb; mode = pm; in_tag = issued[3:0];
            end else begin
                in_valid = 1'b0; in1 = $urandom; in2 = $urandom; mode = 1'($urandom); in_tag = 4'($urandom);
            end
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got unexpected result tag %0d", out_tag);
                end else begin
                    got_e = sbq.pop_front();
                    if ({out_tag, out_H, out_L} !== got_e) begin
                        n_err++; $display("FAIL rand_result: got tag %0d %h_%h want tag %0d %h",
                                          out_tag, out_H, out_L, got_e[67:64], got_e[63:0]); end
                end
            end
            if (in_valid && in_ready) begin
                e = 64'(pa) * 64'(pm ? pa : pb);
                sbq.push_back({in_tag, e});
                issued++;
                offer = 1'b0;
                pa = $urandom_range(0, 343576576); pb = $urandom_range(0, 343576576); pm = 1'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++; if (issued != 1000 || sbq.size() != 0) begin
            n_err++; $display("FAIL rand_count: got issued %0d pending %0d want 1000 0", issued, sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_square();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
